// File: rtl/lstm_step_sequencer_pkg.sv
// rtl/lstm_step_sequencer_pkg.sv - shared states, phase codes and phase-length constants for the LSTM step sequencer
package lstm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_G_START,
    S_G_WAIT,
    S_N_START,
    S_N_WAIT,
    S_FIN,
    S_ERROR
  } seq_state_e;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_GATE = 2'd1;
  localparam logic [1:0] PH_NET  = 2'd2;
  localparam logic [1:0] PH_ERR  = 2'd3;

  // Nominal generator phase lengths; the watchdog limit must cover the longer one.
  localparam int GATE_PHASE_LEN = 1536;
  localparam int NET_PHASE_LEN  = 390;

  // True when a watchdog limit covers both phases and fits in the counter.
  function automatic bit tmo_limit_ok(input int limit, input int width);
    return (limit >= GATE_PHASE_LEN) && (limit >= NET_PHASE_LEN) &&
           (limit < (1 << width));
  endfunction

  // Host-visible phase code for a sequencer state; FIN reports idle.
  function automatic logic [1:0] phase_of(input seq_state_e s);
    case (s)
      S_G_START, S_G_WAIT: return PH_GATE;
      S_N_START, S_N_WAIT: return PH_NET;
      S_ERROR:             return PH_ERR;
      default:             return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lstm_step_sequencer_if.sv
// rtl/lstm_step_sequencer_if.sv - host and generator handshake bundle for the step sequencer
interface lstm_step_sequencer_if #(
  parameter int STEP_W = 8
);
  logic              run;
  logic              abort;
  logic [STEP_W-1:0] num_steps;
  logic              memory_gate_done;
  logic              memory_net_done;
  logic              start_gate;
  logic              start_net;
  logic              busy;
  logic [1:0]        phase;
  logic [STEP_W-1:0] step_idx;
  logic              done;
  logic              err;

  // Sequencer side.
  modport master (
    input  run, abort, num_steps, memory_gate_done, memory_net_done,
    output start_gate, start_net, busy, phase, step_idx, done, err
  );

  // Host and generator side.
  modport slave (
    output run, abort, num_steps, memory_gate_done, memory_net_done,
    input  start_gate, start_net, busy, phase, step_idx, done, err
  );
endinterface

// File: rtl/lstm_step_sequencer_watchdog.sv
// rtl/lstm_step_sequencer_watchdog.sv - saturating per-phase wait counter with expiry flag
import lstm_ctrl_pkg::*;

module phase_watchdog #(
  parameter int TMO_W     = 12,
  parameter int TMO_LIMIT = 2047
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TMO_LIMIT);

  logic [TMO_W-1:0] count;

  // Count wait cycles, parking at the limit so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired = (count == LIMIT);
endmodule

// File: rtl/lstm_step_sequencer.sv
// rtl/lstm_step_sequencer.sv - per-timestep gate/net phase scheduler with watchdog and abort
import lstm_ctrl_pkg::*;

module lstm_step_sequencer #(
  parameter int STEP_W    = 8,
  parameter int TMO_W     = 12,
  parameter int TMO_LIMIT = 2047
) (
  input logic                  clk,
  input logic                  rst,
  lstm_step_sequencer_if.master bus
);
  if (!tmo_limit_ok(TMO_LIMIT, TMO_W)) begin : g_bad_tmo_limit
    $error("TMO_LIMIT must cover the gate phase and fit in TMO_W bits");
  end

  seq_state_e        state;
  logic [STEP_W-1:0] steps_latched;
  logic [STEP_W-1:0] step_q;
  logic              err_q;
  logic              in_wait;
  logic              wd_expired;

  assign in_wait = (state == S_G_WAIT) || (state == S_N_WAIT);

  phase_watchdog #(
    .TMO_W    (TMO_W),
    .TMO_LIMIT(TMO_LIMIT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(wd_expired)
  );

  // Sequencer FSM: abort beats everything, done inputs beat watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      steps_latched <= '0;
      step_q        <= '0;
      err_q         <= 1'b0;
    end else if (bus.abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (bus.run) begin
            steps_latched <= bus.num_steps;
            step_q        <= '0;
            err_q         <= 1'b0;
            state         <= (bus.num_steps == '0) ? S_FIN : S_G_START;
          end
        end
        S_G_START: state <= S_G_WAIT;
        S_G_WAIT: begin
          if (bus.memory_gate_done) begin
            state <= S_N_START;
          end else if (wd_expired) begin
            state <= S_ERROR;
            err_q <= 1'b1;
          end
        end
        S_N_START: state <= S_N_WAIT;
        S_N_WAIT: begin
          if (bus.memory_net_done) begin
            if (step_q == steps_latched - STEP_W'(1)) begin
              state <= S_FIN;
            end else begin
              step_q <= step_q + STEP_W'(1);
              state  <= S_G_START;
            end
          end else if (wd_expired) begin
            state <= S_ERROR;
            err_q <= 1'b1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_gate = (state == S_G_START);
  assign bus.start_net  = (state == S_N_START);
  assign bus.done       = (state == S_FIN);
  assign bus.busy       = (state != S_IDLE) && (state != S_ERROR);
  assign bus.phase      = phase_of(state);
  assign bus.step_idx   = step_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_lstm_step_sequencer.sv
// tb/tb_lstm_step_sequencer.sv - self-checking bench for lstm_step_sequencer
module tb_lstm_step_sequencer;
  localparam int STEP_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lstm_step_sequencer_if #(.STEP_W(STEP_W)) ctl ();

  lstm_step_sequencer #(
    .STEP_W   (STEP_W),
    .TMO_W    (12),
    .TMO_LIMIT(2047)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int gd;
    int nd;
    int exp_gates;
    int exp_nets;
    int exp_t;
    bit exp_done;
    bit exp_err;
    int exp_idx;
  } vec_t;

  vec_t vecs[9];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Directed run: generator answers each start pulse after a fixed delay.
  task automatic run_vec(input vec_t v, input int idx);
    int t, gate_at, net_at, gcnt, ncnt, t_end;
    bit got_done, got_err;
    ctl.num_steps = 8'(v.n);
    ctl.run = 1'b1;
    cycle();
    ctl.run = 1'b0;
    t = 0; gate_at = -1; net_at = -1; gcnt = 0; ncnt = 0; t_end = -1;
    got_done = 1'b0; got_err = 1'b0;
    check($sformatf("v%0d_err_cleared", idx), ctl.err, 0);
    while (t < 8000) begin
      if (ctl.start_gate) begin gcnt++; gate_at = t + v.gd; end
      if (ctl.start_net)  begin ncnt++; net_at = t + v.nd; end
      if (ctl.done) got_done = 1'b1;
      if (ctl.err)  got_err = 1'b1;
      if (got_done || got_err) begin
        t_end = t;
        break;
      end
      ctl.memory_gate_done = (t == gate_at);
      ctl.memory_net_done  = (t == net_at);
      cycle();
      t++;
    end
    ctl.memory_gate_done = 1'b0;
    ctl.memory_net_done  = 1'b0;
    check($sformatf("v%0d_gates", idx), gcnt, v.exp_gates);
    check($sformatf("v%0d_nets", idx), ncnt, v.exp_nets);
    check($sformatf("v%0d_end_time", idx), t_end, v.exp_t);
    check($sformatf("v%0d_done", idx), got_done, v.exp_done);
    check($sformatf("v%0d_err", idx), got_err, v.exp_err);
    check($sformatf("v%0d_step_idx", idx), ctl.step_idx, v.exp_idx);
    if (got_err) begin
      check($sformatf("v%0d_err_phase", idx), ctl.phase, 3);
      check($sformatf("v%0d_err_busy", idx), ctl.busy, 0);
    end else begin
      cycle();
      check($sformatf("v%0d_busy_after", idx), ctl.busy, 0);
      check($sformatf("v%0d_done_once", idx), ctl.done, 0);
    end
  endtask

  // Random run: timeline model of which pulse is due when, with stray inputs.
  task automatic rand_run(input int r);
    int n, k, kind, exp_t, t, gate_at, net_at, cur_ph;
    bit fin;
    n = $urandom_range(0, 6);
    ctl.num_steps = 8'(n);
    ctl.run = 1'b1;
    cycle();
    ctl.run = 1'b0;
    k = 0; kind = (n == 0) ? 2 : 0; exp_t = 0; t = 0;
    gate_at = -1; net_at = -1; cur_ph = 0; fin = 1'b0;
    while (!fin && t < 400) begin
      check($sformatf("r%0d_no_overlap", r), ctl.start_gate & ctl.start_net, 0);
      if (t == exp_t) begin
        if (kind == 0) begin
          check($sformatf("r%0d_start_gate", r), ctl.start_gate, 1);
          check($sformatf("r%0d_gate_idx", r), ctl.step_idx, k);
          gate_at = t + $urandom_range(1, 6);
          cur_ph = 1;
        end else if (kind == 1) begin
          check($sformatf("r%0d_start_net", r), ctl.start_net, 1);
          check($sformatf("r%0d_net_idx", r), ctl.step_idx, k);
          net_at = t + $urandom_range(1, 6);
          cur_ph = 2;
        end else begin
          check($sformatf("r%0d_done", r), ctl.done, 1);
          check($sformatf("r%0d_done_idx", r), ctl.step_idx, (n == 0) ? 0 : n - 1);
          fin = 1'b1;
        end
      end else begin
        check($sformatf("r%0d_no_pulse", r),
              {29'd0, ctl.start_gate, ctl.start_net, ctl.done}, 0);
        check($sformatf("r%0d_busy", r), ctl.busy, 1);
        check($sformatf("r%0d_phase", r), ctl.phase, cur_ph);
      end
      ctl.memory_gate_done = (t == gate_at);
      ctl.memory_net_done  = (t == net_at);
      if (!fin) begin
        if (gate_at >= t && $urandom_range(0, 3) == 0) ctl.memory_net_done = 1'b1;
        if (net_at >= t && $urandom_range(0, 3) == 0)  ctl.memory_gate_done = 1'b1;
        ctl.run = ($urandom_range(0, 4) == 0);
        ctl.num_steps = 8'($urandom_range(0, 255));
      end
      if (t == gate_at) begin kind = 1; exp_t = t + 1; end
      if (t == net_at) begin
        k++;
        kind = (k == n) ? 2 : 0;
        exp_t = t + 1;
      end
      if (!fin) begin
        cycle();
        t++;
      end
    end
    if (!fin) begin
      errors++;
      checks++;
      $display("FAIL r%0d_timeout: got no done expected done by cycle 400", r);
    end
    ctl.run = 1'b0;
    ctl.memory_gate_done = 1'b0;
    ctl.memory_net_done = 1'b0;
    cycle();
    check($sformatf("r%0d_idle_after", r), ctl.busy, 0);
    check($sformatf("r%0d_done_once", r), ctl.done, 0);
    repeat ($urandom_range(0, 3)) cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{3,   1536, 390,  3,   3,   5784, 1'b1, 1'b0, 2};
    vecs[1] = '{0,   1,    1,    0,   0,   0,    1'b1, 1'b0, 0};
    vecs[2] = '{1,   2049, 1,    1,   0,   2049, 1'b0, 1'b1, 0};
    vecs[3] = '{2,   5,    3,    2,   2,   20,   1'b1, 1'b0, 1};
    vecs[4] = '{1,   2048, 1,    1,   1,   2051, 1'b1, 1'b0, 0};
    vecs[5] = '{1,   1,    2049, 1,   1,   2051, 1'b0, 1'b1, 0};
    vecs[6] = '{1,   3,    2048, 1,   1,   2053, 1'b1, 1'b0, 0};
    vecs[7] = '{255, 1,    1,    255, 255, 1020, 1'b1, 1'b0, 254};
    vecs[8] = '{4,   2,    7,    4,   4,   44,   1'b1, 1'b0, 3};

    rst = 1'b1;
    ctl.run = 1'b0;
    ctl.abort = 1'b0;
    ctl.num_steps = '0;
    ctl.memory_gate_done = 1'b0;
    ctl.memory_net_done = 1'b0;
    cycle();
    cycle();
    check("reset_busy", ctl.busy, 0);
    check("reset_phase", ctl.phase, 0);
    check("reset_step_idx", ctl.step_idx, 0);
    check("reset_pulses", {29'd0, ctl.start_gate, ctl.start_net, ctl.done}, 0);
    check("reset_err", ctl.err, 0);
    rst = 1'b0;
    cycle();

    // rst while waiting for gate done
    ctl.num_steps = 8'd2;
    ctl.run = 1'b1;
    cycle();
    ctl.run = 1'b0;
    cycle();
    check("rst_pre_phase", ctl.phase, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_outputs",
          {ctl.busy, ctl.phase, ctl.step_idx, ctl.start_gate, ctl.start_net, ctl.done, ctl.err}, 0);
    cycle();
    check("rst_next_no_start", {ctl.start_gate, ctl.busy}, 0);

    // abort during step 1 net wait, coincident with net done
    ctl.num_steps = 8'd3;
    ctl.run = 1'b1;
    cycle();
    ctl.run = 1'b0;
    check("ab_start_gate0", ctl.start_gate, 1);
    cycle();
    ctl.memory_gate_done = 1'b1;
    cycle();
    ctl.memory_gate_done = 1'b0;
    check("ab_start_net0", ctl.start_net, 1);
    cycle();
    ctl.memory_net_done = 1'b1;
    cycle();
    ctl.memory_net_done = 1'b0;
    check("ab_start_gate1", ctl.start_gate, 1);
    check("ab_idx1", ctl.step_idx, 1);
    cycle();
    ctl.memory_gate_done = 1'b1;
    cycle();
    ctl.memory_gate_done = 1'b0;
    check("ab_start_net1", ctl.start_net, 1);
    cycle();
    check("ab_net_wait_phase", ctl.phase, 2);
    ctl.abort = 1'b1;
    ctl.memory_net_done = 1'b1;
    cycle();
    ctl.abort = 1'b0;
    ctl.memory_net_done = 1'b0;
    check("ab_idle_busy", ctl.busy, 0);
    check("ab_idle_phase", ctl.phase, 0);
    check("ab_no_done", ctl.done, 0);
    check("ab_idx_held", ctl.step_idx, 1);
    cycle();
    check("ab_still_no_done", {ctl.done, ctl.start_gate}, 0);
    ctl.num_steps = 8'd2;
    ctl.run = 1'b1;
    cycle();
    ctl.run = 1'b0;
    check("ab_restart_gate", ctl.start_gate, 1);
    check("ab_restart_idx", ctl.step_idx, 0);
    ctl.abort = 1'b1;
    cycle();
    ctl.abort = 1'b0;
    check("ab_cleanup_busy", ctl.busy, 0);

    // abort and run together in idle: run dropped
    ctl.abort = 1'b1;
    ctl.run = 1'b1;
    cycle();
    ctl.abort = 1'b0;
    ctl.run = 1'b0;
    check("abrun_busy", ctl.busy, 0);
    cycle();
    check("abrun_no_start", ctl.start_gate, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    for (int r = 0; r < 40; r++) rand_run(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
